// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: default width, FSM state
// encodings and the counter-width helper.
package serial_adder_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;

    // 2'd3 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Gate-level single-bit full adder used as the serial adder's datapath.
module fa_cell (
    input  logic A_in,
    input  logic B_in,
    input  logic C_in,
    output logic Sum_out,
    output logic C_out
);

    logic ab_x;

    assign ab_x    = A_in ^ B_in;
    assign Sum_out = ab_x ^ C_in;
    assign C_out   = (A_in & B_in) | (ab_x & C_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first, carry held
// in a flop between cycles, result latched in parallel on completion.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] A_par_in,
    input  logic [WIDTH-1:0] B_par_in,
    input  logic             C_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] Sum_par_out,
    output logic             C_out
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] sh_s_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_next;

    fa_cell u_fa_cell (
        .A_in    (sh_a_q[0]),
        .B_in    (sh_b_q[0]),
        .C_in    (carry_q),
        .Sum_out (fa_sum),
        .C_out   (fa_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign sum_next = WIDTH'({fa_sum, sh_s_q} >> 1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            sh_s_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            Sum_par_out <= '0;
            C_out       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        sh_a_q   <= A_par_in;
                        sh_b_q   <= B_par_in;
                        carry_q  <= C_in;
                        cnt_q    <= '0;
                        busy_out <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    sh_a_q  <= sh_a_q >> 1;
                    sh_b_q  <= sh_b_q >> 1;
                    sh_s_q  <= sum_next;
                    carry_q <= fa_carry;
                    if (cnt_q == CntLast) begin
                        Sum_par_out <= sum_next;
                        C_out       <= fa_carry;
                        done_out    <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule
